// File: rtl/cpu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | cpu_pkg : widths and encodings shared across the pipelined MIPS CPU.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // "No destination" encoding, shared with the W_reg/M_reg dst fields
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | rf_read_port : one combinational register-file read port.               |
// | Optional write-through bypass when REGFILE_BYPASS_EN is defined.        |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module rf_read_port
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic [ADDR_W-1:0] i_src,
  input  logic [DATA_W-1:0] i_regs [2**ADDR_W],
`ifdef REGFILE_BYPASS_EN
  input  logic              i_reset,
  input  logic [ADDR_W-1:0] i_dstE,
  input  logic [DATA_W-1:0] i_valE,
  input  logic [ADDR_W-1:0] i_dstM,
  input  logic [DATA_W-1:0] i_valM,
`endif
  output logic [DATA_W-1:0] o_rval
);

  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  always_comb begin
    o_rval = '0;
    if (i_src != C_ZERO) begin
`ifdef REGFILE_BYPASS_EN
      // Reset is itself a write of zero to every entry, so it is what passes through.
      if (i_reset)
        o_rval = '0;
      else if (i_src == i_dstM)
        o_rval = i_valM;
      else if (i_src == i_dstE)
        o_rval = i_valE;
      else
        o_rval = i_regs[i_src];
`else
      o_rval = i_regs[i_src];
`endif
    end
  end

endmodule : rf_read_port
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | register_file : MIPS GPR file, two W-stage writes, two async reads.     |
// | Define REGFILE_BYPASS_EN for same-cycle write-through on the reads.     |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module register_file
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [ADDR_W-1:0] W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [ADDR_W-1:0] d_srcA,
  input  logic [ADDR_W-1:0] d_srcB,
  output logic [DATA_W-1:0] d_rvalA,
  output logic [DATA_W-1:0] d_rvalB
);

  localparam int                NREGS  = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] C_ZERO = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] r_regs [NREGS];

  // M is written after E so a same-destination collision resolves to the load.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (W_dstE != C_ZERO) r_regs[W_dstE] <= W_valE;
      if (W_dstM != C_ZERO) r_regs[W_dstM] <= W_valM;
    end
  end

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readA (
    .i_src   (d_srcA),
    .i_regs  (r_regs),
`ifdef REGFILE_BYPASS_EN
    .i_reset (reset),
    .i_dstE  (W_dstE),
    .i_valE  (W_valE),
    .i_dstM  (W_dstM),
    .i_valM  (W_valM),
`endif
    .o_rval  (d_rvalA)
  );

  rf_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_readB (
    .i_src   (d_srcB),
    .i_regs  (r_regs),
`ifdef REGFILE_BYPASS_EN
    .i_reset (reset),
    .i_dstE  (W_dstE),
    .i_valE  (W_valE),
    .i_dstM  (W_dstM),
    .i_valM  (W_valM),
`endif
    .o_rval  (d_rvalB)
  );

endmodule : register_file
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_register_file : directed + random checks of register_file against a |
// | behavioural array model. Honours REGFILE_BYPASS_EN. Revision: 1.0       |
// +-------------------------------------------------------------------------+
module tb_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  W_dstE, W_dstM, d_srcA, d_srcB;
  logic [31:0] W_valE, W_valM;
  logic [31:0] d_rvalA, d_rvalB;

  int errors = 0;
  int checks = 0;

  logic [31:0] model [32];
  bit          modelValid = 1'b0;
  bit          done = 1'b0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  register_file dut (
    .clk     (clk),
    .reset   (reset),
    .W_dstE  (W_dstE),
    .W_valE  (W_valE),
    .W_dstM  (W_dstM),
    .W_valM  (W_valM),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .d_rvalA (d_rvalA),
    .d_rvalB (d_rvalB)
  );

  always #5 clk = ~clk;

  // Reference: what a read of index src must return in the current cycle.
  function automatic logic [31:0] expRead(input logic [4:0] src);
    if (src == 0) return 32'h0;
    if (BYP) begin
      if (reset) return 32'h0;
      if (W_dstM == src) return W_valM;
      if (W_dstE == src) return W_valE;
    end
    return model[src];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Model state update: the architectural effect of each edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      modelValid = 1'b1;
    end else begin
      if (W_dstE != 0) model[W_dstE] = W_valE;
      if (W_dstM != 0) model[W_dstM] = W_valM;
    end
  end

  // Continuous comparison on every cycle once the model is defined.
  always @(negedge clk) begin
    if (modelValid && !done) begin
      chk("rvalA", d_rvalA, expRead(d_srcA));
      chk("rvalB", d_rvalB, expRead(d_srcB));
    end
  end

  task automatic drive(input logic rst, input logic [4:0] de, input logic [31:0] ve,
                       input logic [4:0] dm, input logic [31:0] vm,
                       input logic [4:0] sa, input logic [4:0] sb);
    @(posedge clk);
    #1;
    reset = rst; W_dstE = de; W_valE = ve; W_dstM = dm; W_valM = vm;
    d_srcA = sa; d_srcB = sb;
  endtask

  initial begin
    reset = 1'b1; W_dstE = 0; W_valE = 0; W_dstM = 0; W_valM = 0;
    d_srcA = 0; d_srcB = 0;

    // Reset then read
    drive(0, 0, 0, 0, 0, 5, 31);
    @(negedge clk);
    chk("reset_A", d_rvalA, 32'h0);
    chk("reset_B", d_rvalB, 32'h0);

    // Dual write
    drive(0, 3, 32'h11, 4, 32'h22, 3, 4);
    @(negedge clk);
    chk("dual_same_A", d_rvalA, BYP ? 32'h11 : 32'h0);
    chk("dual_same_B", d_rvalB, BYP ? 32'h22 : 32'h0);
    drive(0, 0, 0, 0, 0, 3, 4);
    @(negedge clk);
    chk("dual_next_A", d_rvalA, 32'h11);
    chk("dual_next_B", d_rvalB, 32'h22);

    // Collision: M wins
    drive(0, 7, 32'hAAAA, 7, 32'h5555, 7, 7);
    @(negedge clk);
    chk("coll_same", d_rvalA, BYP ? 32'h5555 : 32'h0);
    drive(0, 0, 0, 0, 0, 7, 3);
    @(negedge clk);
    chk("coll_next", d_rvalA, 32'h5555);

    // Register 0 is never written
    drive(0, 0, 32'hFFFF_FFFF, 0, 32'h1234_5678, 0, 3);
    drive(0, 0, 0, 0, 0, 0, 4);
    @(negedge clk);
    chk("reg0", d_rvalA, 32'h0);
    chk("reg0_other", d_rvalB, 32'h22);

    // Reset mid-stream discards the same-cycle write
    drive(0, 9, 32'h1234, 0, 0, 9, 7);
    drive(1, 9, 32'hBEEF, 0, 0, 9, 7);
    @(negedge clk);
    chk("rst_mid_cycle", d_rvalA, BYP ? 32'h0 : 32'h1234);
    drive(0, 0, 0, 0, 0, 9, 7);
    @(negedge clk);
    chk("rst_mid_after", d_rvalA, 32'h0);
    chk("rst_mid_other", d_rvalB, 32'h0);

    // Randomised traffic with occasional resets and forced collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] de, dm;
      de = 5'($urandom_range(0, 31));
      dm = ($urandom_range(0, 7) == 0) ? de : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 39) == 0), de, $urandom, dm, $urandom,
            ($urandom_range(0, 3) == 0) ? dm : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 3) == 0) ? de : 5'($urandom_range(0, 31)));
    end

    @(negedge clk);
    done = 1'b1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file
`default_nettype wire
